// File: rtl/fix_msg_framer.sv
// fix_msg_framer
//   Ingress framer in front of the FIX parser. It finds message boundaries
//   ("8=" through the SOH that ends tag 10) in a raw byte stream. In-message
//   bytes are forwarded with one cycle of latency. The tag 10 checksum is
//   checked, and the tag 9 body length is checked when length checking is
//   built in. Completed messages and error pulses are counted.
//
//   Build option: define FIX_LEN_CHECK_EN to build the body-length check.
//   Without it, len_ok_o is 1 on every msg_end_o and only the checksum
//   decides err_o at the end of a message.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   data_i, valid_i   raw byte stream, no backpressure
//   data_o, valid_o   forwarded message byte (data_o is 0 when not valid)
//   msg_start_o       pulse with the forwarded leading '8'
//   msg_end_o         pulse with the forwarded SOH that ends tag 10
//   csum_ok_o         checksum matched (only meaningful with msg_end_o)
//   len_ok_o          body length matched (only meaningful with msg_end_o)
//   err_o             pulse on a failed check or an abort
//   msg_count_o       completed messages, wrapping
//   err_count_o       err_o pulses, wrapping
module fix_msg_framer #(
    parameter int MAX_MSG_LEN = 1024,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           data_i,
    input  logic                 valid_i,
    output logic [7:0]           data_o,
    output logic                 valid_o,
    output logic                 msg_start_o,
    output logic                 msg_end_o,
    output logic                 csum_ok_o,
    output logic                 len_ok_o,
    output logic                 err_o,
    output logic [CNT_WIDTH-1:0] msg_count_o,
    output logic [CNT_WIDTH-1:0] err_count_o
);

    localparam int CW = $clog2(MAX_MSG_LEN + 2);

    typedef enum logic [1:0] {IDLE, TAG, VAL, CSUM} state_t;

    state_t        state_q, state_d;
    logic [15:0]   tag_acc, val_acc;
    logic [7:0]    sum_acc, csum_snap;
    logic [9:0]    csum_val;
    logic [2:0]    csum_digits;
    logic          csum_bad;
    logic [CW-1:0] fwd_cnt, cnt_next;

    logic       is_digit, is_soh, is_eq;
    logic [3:0] digit;
    logic       fwd, start, fin, abort, csum_ok_c, len_ok_c, err_c;

`ifdef FIX_LEN_CHECK_EN
    logic [15:0] len_decl, body_cnt, body_snap;
    logic        len_seen, body_on;
`endif

    // Decimal accumulate, saturating at 16 bits.
    function automatic logic [15:0] dec_acc(input logic [15:0] a, input logic [3:0] d);
        logic [19:0] t;
        t = {4'b0, a} * 20'd10 + {16'b0, d};
        return (t > 20'h0FFFF) ? 16'hFFFF : t[15:0];
    endfunction

    assign is_digit = (data_i >= 8'h30) && (data_i <= 8'h39);
    assign digit    = data_i[3:0];
    assign is_soh   = (data_i == 8'h01);
    assign is_eq    = (data_i == 8'h3D);
    // Position of this byte within the message if it gets forwarded.
    assign cnt_next = (state_q == IDLE) ? CW'(1) : fwd_cnt + CW'(1);

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        fwd     = 1'b0;
        start   = 1'b0;
        fin     = 1'b0;
        abort   = 1'b0;
        if (valid_i) begin
            case (state_q)
                IDLE: if (data_i == 8'h38) begin
                    fwd     = 1'b1;
                    start   = 1'b1;
                    state_d = TAG;
                end
                TAG: begin
                    fwd = 1'b1;
                    if (is_eq)          state_d = (tag_acc == 16'd10) ? CSUM : VAL;
                    else if (!is_digit) abort = 1'b1;
                end
                VAL: begin
                    fwd = 1'b1;
                    if (is_soh) state_d = TAG;
                end
                CSUM: begin
                    fwd = 1'b1;
                    if (is_soh) begin
                        fin     = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
            // The overlong byte is still forwarded, then the message is dropped.
            if (fwd && state_q != IDLE && cnt_next == CW'(MAX_MSG_LEN + 1)) abort = 1'b1;
            if (abort) begin
                fin     = 1'b0;
                state_d = IDLE;
            end
        end
    end

    assign csum_ok_c = (csum_digits == 3'd3) && !csum_bad && (csum_val == {2'b00, csum_snap});
`ifdef FIX_LEN_CHECK_EN
    assign len_ok_c  = len_seen && (body_snap == len_decl);
`else
    assign len_ok_c  = 1'b1;
`endif
    assign err_c = abort || (fin && !(csum_ok_c && len_ok_c));

    always_ff @(posedge clk) begin
        if (rst) begin
            data_o      <= '0;
            valid_o     <= 1'b0;
            msg_start_o <= 1'b0;
            msg_end_o   <= 1'b0;
            csum_ok_o   <= 1'b0;
            len_ok_o    <= 1'b0;
            err_o       <= 1'b0;
            msg_count_o <= '0;
            err_count_o <= '0;
            tag_acc     <= '0;
            val_acc     <= '0;
            sum_acc     <= '0;
            csum_snap   <= '0;
            csum_val    <= '0;
            csum_digits <= '0;
            csum_bad    <= 1'b0;
            fwd_cnt     <= '0;
`ifdef FIX_LEN_CHECK_EN
            len_decl    <= '0;
            len_seen    <= 1'b0;
            body_on     <= 1'b0;
            body_cnt    <= '0;
            body_snap   <= '0;
`endif
        end else begin
            valid_o     <= fwd;
            data_o      <= fwd ? data_i : 8'h00;
            msg_start_o <= start;
            msg_end_o   <= fin;
            csum_ok_o   <= fin && csum_ok_c;
            len_ok_o    <= fin && len_ok_c;
            err_o       <= err_c;
            if (fin)   msg_count_o <= msg_count_o + 1'b1;
            if (err_c) err_count_o <= err_count_o + 1'b1;

            if (fwd) begin
                fwd_cnt <= cnt_next;
                if (start) begin
                    sum_acc     <= data_i;
                    tag_acc     <= 16'd8;
                    val_acc     <= '0;
                    csum_snap   <= '0;
                    csum_val    <= '0;
                    csum_digits <= '0;
                    csum_bad    <= 1'b0;
`ifdef FIX_LEN_CHECK_EN
                    len_decl    <= '0;
                    len_seen    <= 1'b0;
                    body_on     <= 1'b0;
                    body_cnt    <= '0;
                    body_snap   <= '0;
`endif
                end else begin
                    sum_acc <= sum_acc + data_i;
                    // Snapshot includes the SOH itself; the one taken before
                    // "10=" is what the checksum field is compared against.
                    if (is_soh) csum_snap <= sum_acc + data_i;
                    case (state_q)
                        TAG:  if (is_digit) tag_acc <= dec_acc(tag_acc, digit);
                              else if (is_eq) val_acc <= '0;
                        VAL:  if (is_digit) val_acc <= dec_acc(val_acc, digit);
                              else if (is_soh) tag_acc <= '0;
                        CSUM: if (is_digit && csum_digits < 3'd3) begin
                                  csum_val    <= 10'(csum_val * 10'd10 + {6'b0, digit});
                                  csum_digits <= csum_digits + 3'd1;
                              end else if (!is_soh) begin
                                  csum_bad <= 1'b1;
                              end
                        default: ;
                    endcase
`ifdef FIX_LEN_CHECK_EN
                    // Body counting starts on the byte after the SOH ending tag 9.
                    if (state_q == VAL && is_soh && tag_acc == 16'd9) begin
                        len_decl <= val_acc;
                        len_seen <= 1'b1;
                        body_on  <= 1'b1;
                        body_cnt <= '0;
                    end else if (body_on) begin
                        body_cnt <= body_cnt + 16'd1;
                    end
                    if (is_soh) body_snap <= body_on ? body_cnt + 16'd1 : 16'd0;
`endif
                end
            end
        end
    end

endmodule

// File: doc/fix_msg_framer.md
Name: fix_msg_framer

Overview:
- Ingress stage directly upstream of the FIX parser top. It receives the raw byte stream and locates message boundaries ("8=" through the SOH that ends tag 10).
- Forwards in-message bytes to the parser's data_i with one cycle of latency.
- Validates each message's checksum (tag 10) and body length (tag 9), and keeps message and error counters.

Parameters:
- MAX_MSG_LEN, 1024: max forwarded bytes per message; exceeding it aborts the message.
- CNT_WIDTH, 16: width of msg_count_o and err_count_o.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- data_i  in  8  raw byte
- valid_i  in  1  data_i valid this cycle; no backpressure, so every valid byte is consumed
- data_o  out  8  forwarded byte (to parser data_i); 8'h00 when valid_o=0
- valid_o  out  1  data_o holds a message byte
- msg_start_o  out  1  pulse, aligned with the forwarded '8' byte
- msg_end_o  out  1  pulse, aligned with the forwarded SOH that ends tag 10
- csum_ok_o  out  1  valid only with msg_end_o: checksum matched
- len_ok_o  out  1  valid only with msg_end_o: body length matched
- err_o  out  1  pulse on a failed check or an abort
- msg_count_o  out  CNT_WIDTH  count of completed messages (ok or not)
- err_count_o  out  CNT_WIDTH  count of err_o pulses

Behaviour:
- Reset:
  - Every output is 0 on the cycle after rst is sampled high; FSM goes to IDLE; accumulators and counters clear.
  - A reset mid-message discards the message: no msg_end_o and no err_o are produced for it.
- Stall: when valid_i=0, all state holds and valid_o and all pulse outputs are 0.
- Latency: every output is registered, exactly 1 cycle after the input byte.
- SOH = 8'h01.
- FSM states: IDLE, TAG, VAL, CSUM, with these transitions:
  - IDLE: drop bytes (not forwarded). On '8', forward it, assert msg_start_o, clear accumulators, go to TAG with tag_acc=8.
  - TAG:
    - On a digit: tag_acc = tag_acc*10 + digit, saturating at 16 bits.
    - On '=': if tag_acc==10 go to CSUM, else go to VAL.
    - On any other byte: abort.
  - VAL: on SOH, go to TAG with tag_acc=0. If the field's tag is 9, its decimal value is latched as len_decl.
  - CSUM:
    - Accepts exactly 3 ASCII digits into csum_val.
    - On SOH: assert msg_end_o and go to IDLE.
    - csum_ok_o=1 only if exactly 3 digits were seen and csum_val == csum_snap.
    - A non-digit other than SOH, or a 4th digit, leaves csum_ok_o=0 at end.
- Checksum arithmetic:
  - sum_acc = 8-bit wrap sum of all forwarded bytes.
  - Each SOH (including its own value) updates csum_snap <= sum_acc + byte.
  - The value compared is the snapshot at the SOH preceding "10=".
- Body length:
  - body_cnt starts at 0 on the byte after the SOH ending tag 9.
  - It counts each forwarded byte; body_snap is latched at every SOH (inclusive).
  - len_ok_o = (body_snap at the SOH before "10=" == len_decl).
  - If no tag 9 was seen, len_ok_o=0.
- Abort:
  - Triggers: a non-digit/non-'=' byte in TAG, or the forwarded byte count reaching MAX_MSG_LEN+1.
  - Action: the offending byte is forwarded, err_o pulses, no msg_end_o is produced, and the FSM goes to IDLE.
- At msg_end_o:
  - msg_count_o increments.
  - If !(csum_ok && len_ok), err_o pulses in the same cycle.
- Counters: err_count_o increments on every err_o pulse. Both counters wrap.
- Back-to-back messages: an '8' on the cycle right after the terminating SOH starts a new message with no gap.

Optional Feature:
- FIX_LEN_CHECK_EN defined: body length tracking and the len_ok_o check behave as above.
- Undefined: no len_decl/body_cnt logic; len_ok_o=1 whenever msg_end_o=1; err_o at end depends only on csum_ok.

Test Plan:
- Good message: feed "8=FIX.4.2|9=5|35=0|10=161|" (|=SOH, 26 bytes).
  - Expect 26 forwarded bytes, msg_start_o on byte 1, msg_end_o on byte 26.
  - Expect csum_ok_o=1, len_ok_o=1, err_o=0, msg_count_o=1.
- Bad checksum: same message with "10=162".
  - Expect msg_end_o with csum_ok_o=0, len_ok_o=1, err_o=1, err_count_o=1.
- Bad length: "8=FIX.4.2|9=6|35=0|" with the correct checksum for that text.
  - Expect len_ok_o=0 and err_o=1 (with FIX_LEN_CHECK_EN).
  - Without the macro: len_ok_o=1, err_o=0.
- Garbage and gaps:
  - "xyz" before the good message: those 3 bytes are not forwarded (valid_o=0); the message is then accepted as in the first case.
  - Random valid_i=0 gaps inside the message give identical results.
- Abort:
  - "8=FIX|3A=" gives err_o on 'A' with no msg_end_o; the next good message passes.
  - With MAX_MSG_LEN=16, the good message aborts on byte 17.
- Reset mid-message: assert rst at byte 12.
  - Next cycle all outputs and counters are 0.
  - The remaining bytes are dropped until the next '8'.
